// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency, critical-word-first block fill responder; define MEM_STALL_CNT_EN to enable stall_count
module mem_fill_responder #(
  parameter int          LATENCY     = 100,
  parameter int          BLOCK_WORDS = 4,
  parameter logic [20:0] DATA_TAG    = 21'h1BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [10:0] resp_addr,
  output logic        resp_last,
  output logic [31:0] req_count,
  output logic [31:0] beat_count,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [10:0] MASK = 11'(BLOCK_WORDS - 1);
  localparam logic [4:0] LASTK = 5'(BLOCK_WORDS - 1);
  state_t state, state_d;
  logic [LW-1:0] lat, lat_d;
  logic [10:0] crit, crit_d, addr_d;
  logic [4:0] k, k_d;
  logic ready_d, valid_d, last_d, xfer;
  logic [31:0] data_d, req_count_d, beat_count_d;
  function automatic logic [10:0] beat_addr(input logic [10:0] c, input logic [4:0] i);
    return (c & ~MASK) | ((c + {6'd0, i}) & MASK);
  endfunction
  function automatic logic [31:0] sat(input logic [31:0] x);
    return &x ? x : x + 32'd1;
  endfunction
  assign xfer = resp_valid && resp_ready;
  always_comb begin
    state_d = state;
    lat_d = lat;
    crit_d = crit;
    k_d = k;
    ready_d = req_ready;
    valid_d = resp_valid;
    last_d = resp_last;
    addr_d = resp_addr;
    data_d = resp_data;
    req_count_d = req_count;
    beat_count_d = xfer ? sat(beat_count) : beat_count;
    case (state)
      S_IDLE: if (req_valid) begin
        crit_d = req_addr;
        lat_d = LW'(LATENCY - 1);
        ready_d = 1'b0;
        req_count_d = sat(req_count);
        state_d = S_WAIT;
      end
      S_WAIT: if (lat == '0) begin
        state_d = S_BURST;
        k_d = '0;
        valid_d = 1'b1;
        addr_d = beat_addr(crit, 5'd0);
        data_d = {DATA_TAG, addr_d};
        last_d = LASTK == 5'd0;
      end else lat_d = lat - LW'(1);
      S_BURST: if (xfer && resp_last) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d = 1'b0;
        ready_d = 1'b1;
      end else if (xfer) begin
        k_d = k + 5'd1;
        addr_d = beat_addr(crit, k_d);
        data_d = {DATA_TAG, addr_d};
        last_d = k_d == LASTK;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      lat <= '0;
      crit <= '0;
      k <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_last <= 1'b0;
      resp_addr <= '0;
      resp_data <= '0;
      req_count <= '0;
      beat_count <= '0;
    end else begin
      state <= state_d;
      lat <= lat_d;
      crit <= crit_d;
      k <= k_d;
      req_ready <= ready_d;
      resp_valid <= valid_d;
      resp_last <= last_d;
      resp_addr <= addr_d;
      resp_data <= data_d;
      req_count <= req_count_d;
      beat_count <= beat_count_d;
    end
  end
`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk)
    stall_count <= rst ? '0 : (resp_valid && !resp_ready) ? sat(stall_count) : stall_count;
`else
  assign stall_count = 32'h0;
`endif
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: randomized scoreboard bench for mem_fill_responder against a queue-based fill model
module tb_mem_fill_responder;
  localparam int LAT = 100;
  localparam int BW = 4;
  localparam logic [20:0] TAG = 21'h1BEEF;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, resp_ready = 1'b1;
  logic [10:0] req_addr = '0;
  logic req_ready, resp_valid, resp_last;
  logic [31:0] resp_data, req_count, beat_count, stall_count;
  logic [10:0] resp_addr;
  mem_fill_responder #(.LATENCY(LAT), .BLOCK_WORDS(BW), .DATA_TAG(TAG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_addr(resp_addr),
    .resp_last(resp_last), .req_count(req_count), .beat_count(beat_count), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  typedef struct {logic [10:0] a; logic last; int first;} beat_t;
  beat_t q[$];
  int total = 0, bad = 0, cyc = 0;
  int m_req = 0, m_beat = 0, m_stall = 0, burst_start = 0, burst_stalls = 0, last_xfer = -10, acc_neg = 0;
  bit busy = 0, started = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_req = 0; m_beat = 0; m_stall = 0; busy = 0; started = 0;
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      chk("req_count", req_count, m_req);
      chk("beat_count", beat_count, m_beat);
`ifdef MEM_STALL_CNT_EN
      chk("stall_count", stall_count, m_stall);
`else
      chk("stall_count", stall_count, 32'd0);
`endif
      if (resp_valid && q.size() == 0) chk("spurious_beat", {31'd0, resp_valid}, 32'd0);
      else if (resp_valid) begin
        if (!started) begin
          chk("first_beat_cycle", cyc, q[0].first);
          started = 1; burst_start = cyc; burst_stalls = 0;
        end
        chk("resp_addr", {21'd0, resp_addr}, {21'd0, q[0].a});
        chk("resp_data", resp_data, {TAG, q[0].a});
        chk("resp_last", {31'd0, resp_last}, {31'd0, q[0].last});
        if (resp_ready) begin
          if (q[0].last) begin
            chk("burst_len", cyc - burst_start + 1, BW + burst_stalls);
            busy = 0; started = 0; last_xfer = cyc;
          end
          void'(q.pop_front());
          m_beat++;
        end else begin
          m_stall++; burst_stalls++;
        end
      end else chk("resp_last_idle", {31'd0, resp_last}, 32'd0);
      if (req_valid && req_ready) begin
        for (int i = 0; i < BW; i++) begin
          beat_t b;
          b.a = 11'((int'(req_addr) / BW) * BW + (int'(req_addr) + i) % BW);
          b.last = (i == BW - 1);
          b.first = cyc + 1 + LAT;
          q.push_back(b);
        end
        m_req++; busy = 1; acc_neg = cyc;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_last", {31'd0, resp_last}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_addr", {21'd0, resp_addr}, 32'd0);
    chk("rst_counts", req_count | beat_count | stall_count, 32'd0);
    tick();
    rst = 1'b0;
  endtask
  task automatic send(input logic [10:0] a);
    int r0, n;
    r0 = m_req; n = 0;
    req_addr = a; req_valid = 1'b1;
    do begin tick(); n++; end while (m_req == r0 && n < 300);
    req_valid = 1'b0;
    if (m_req == r0) chk("accept_timeout", {31'd0, req_ready}, 32'd0);
  endtask
  task automatic wait_done(input bit rnd);
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < LAT + 400) begin
      if (rnd) begin
        resp_ready = ($urandom_range(0, 3) != 0);
        req_valid = busy && $urandom_range(0, 1) == 1;
        req_addr = 11'($urandom);
      end
      tick(); n++;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    if (n >= LAT + 400) chk("done_timeout", {31'd0, busy}, 32'd0);
  endtask
  task automatic wait_beats(input int nb);
    int b0, n;
    b0 = m_beat; n = 0;
    while (m_beat < b0 + nb && n < LAT + 50) begin tick(); n++; end
    if (m_beat < b0 + nb) chk("beat_timeout", m_beat, b0 + nb);
  endtask
  initial begin
    int r0;
    do_reset();
    send(11'h006);
    wait_done(0);
    chk("t1_req_count", req_count, 32'd1);
    chk("t1_beat_count", beat_count, 32'd4);
    send(11'h006);
    wait_beats(1);
    resp_ready = 1'b0;
    repeat (5) tick();
    resp_ready = 1'b1;
    wait_done(0);
`ifdef MEM_STALL_CNT_EN
    chk("t2_stall_count", stall_count, 32'd5);
`else
    chk("t2_stall_count", stall_count, 32'd0);
`endif
    send(11'h7FE);
    wait_done(0);
    send(11'h123);
    repeat (48) tick();
    do_reset();
    repeat (LAT + 10) tick();
    send(11'h0A9);
    wait_done(0);
    send(11'h3C4);
    wait_beats(2);
    do_reset();
    repeat (LAT + 10) tick();
    send(11'h555);
    wait_done(0);
    r0 = m_req;
    req_addr = 11'h010; req_valid = 1'b1;
    for (int n = 0; n < 300 && m_req == r0; n++) tick();
    req_addr = 11'h21B;
    for (int n = 0; n < 2 * LAT + 50 && m_req < r0 + 2; n++) tick();
    req_valid = 1'b0;
    chk("b2b_gap", acc_neg, last_xfer + 1);
    wait_done(0);
    chk("b2b_req_count", req_count, 32'(r0 + 2));
    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(11'($urandom));
      wait_done(1);
    end
    repeat (3) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
